// File: rtl/train_sample_feeder_if.sv
// Sample-feeder bus: set loading, read-out handshake and status.
// The controller side is master; the feeder is slave.
interface train_sample_feeder_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int EPOCH_W = 8
);
  logic              clr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_x1;
  logic [DATA_W-1:0] wr_x2;
  logic [DATA_W-1:0] wr_t;
  logic              next;
  logic              rewind;
  logic [DATA_W-1:0] x1;
  logic [DATA_W-1:0] x2;
  logic [DATA_W-1:0] t;
  logic              valid;
  logic              eof;
  logic              empty;
  logic              full;
  logic              ovf;
  logic [ADDR_W:0]   count;
  logic [EPOCH_W-1:0] epoch;

  modport master (
    output clr, wr_en, wr_x1, wr_x2, wr_t,
    output next, rewind,
    input  x1, x2, t, valid, eof,
    input  empty, full, ovf, count, epoch
  );

  modport slave (
    input  clr, wr_en, wr_x1, wr_x2, wr_t,
    input  next, rewind,
    output x1, x2, t, valid, eof,
    output empty, full, ovf, count, epoch
  );
endinterface

// File: rtl/train_sample_feeder.sv
// Training-set store presenting one (x1,x2,t) sample per next pulse.
// FEEDER_AUTO_REWIND_EN: next past the last sample wraps to sample 0.
module train_sample_feeder #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int EPOCH_W = 8
) (
  input logic clk,
  input logic rst,
  train_sample_feeder_if.slave bus
);
  localparam int SMP_W = 3 * DATA_W;
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [SMP_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W:0]    r_count;
  logic [ADDR_W:0]    r_rd_ptr;
  logic [DATA_W-1:0]  r_x1;
  logic [DATA_W-1:0]  r_x2;
  logic [DATA_W-1:0]  r_t;
  logic               r_valid;
  logic               r_eof;
  logic               r_ovf;
  logic [EPOCH_W-1:0] r_epoch;

  logic               w_full;
  logic               w_empty;
  logic               w_wr;
  logic               w_rd;
  logic [SMP_W-1:0]   w_rd_data;
  logic [EPOCH_W-1:0] w_epoch_inc;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_wr    = bus.wr_en && !w_full && !bus.clr;
  assign w_rd    = bus.next && (r_rd_ptr < r_count);
  assign w_rd_data = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign w_epoch_inc = (r_epoch == '1) ? r_epoch
                                       : r_epoch + 1'b1;

`ifdef FEEDER_AUTO_REWIND_EN
  logic w_wrap;
  assign w_wrap = bus.next && (r_rd_ptr == r_count)
               && !w_empty;
`endif

  // Storage is never reset; only written slots are ever read.
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_count[ADDR_W-1:0]] <=
        {bus.wr_x1, bus.wr_x2, bus.wr_t};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_x1     <= '0;
      r_x2     <= '0;
      r_t      <= '0;
      r_valid  <= 1'b0;
      r_eof    <= 1'b0;
      r_ovf    <= 1'b0;
      r_epoch  <= '0;
    end else if (bus.clr) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_x1     <= '0;
      r_x2     <= '0;
      r_t      <= '0;
      r_valid  <= 1'b0;
      r_eof    <= 1'b0;
      r_ovf    <= 1'b0;
      r_epoch  <= '0;
    end else begin
      if (w_wr)
        r_count <= r_count + 1'b1;
      else if (bus.wr_en)
        r_ovf <= 1'b1;

      if (bus.rewind) begin
        r_rd_ptr <= '0;
        r_eof    <= 1'b0;
        r_valid  <= 1'b0;
        r_epoch  <= w_epoch_inc;
      end else if (w_rd) begin
        {r_x1, r_x2, r_t} <= w_rd_data;
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_valid  <= 1'b1;
        r_eof    <= ((r_rd_ptr + 1'b1) == r_count);
      end
`ifdef FEEDER_AUTO_REWIND_EN
      else if (w_wrap) begin
        {r_x1, r_x2, r_t} <= r_mem[0];
        r_rd_ptr <= CNT_ONE;
        r_valid  <= 1'b1;
        r_eof    <= (r_count == CNT_ONE);
        r_epoch  <= w_epoch_inc;
      end
`endif
    end
  end

  assign bus.x1    = r_x1;
  assign bus.x2    = r_x2;
  assign bus.t     = r_t;
  assign bus.valid = r_valid;
  assign bus.eof   = r_eof;
  assign bus.empty = w_empty;
  assign bus.full  = w_full;
  assign bus.ovf   = r_ovf;
  assign bus.count = r_count;
  assign bus.epoch = r_epoch;
endmodule

// File: tb/tb_train_sample_feeder.sv
// Directed bench for train_sample_feeder.
// Also builds with FEEDER_AUTO_REWIND_EN defined.
module tb_train_sample_feeder;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int EW = 8;

  logic clk;
  logic rst;
  int errors = 0;
  int checks = 0;
  int exp_epoch = 0;

  int sx1[3] = '{1, -3, 5};
  int sx2[3] = '{2, 4, -6};
  int st[3]  = '{1, -1, 1};

  train_sample_feeder_if #(
    .DATA_W(DW), .ADDR_W(AW), .EPOCH_W(EW)
  ) bus ();

  train_sample_feeder #(
    .DATA_W(DW), .DEPTH(DEPTH),
    .ADDR_W(AW), .EPOCH_W(EW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic write_sample(input int a, input int b, input int c);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_x1 = DW'(a);
    bus.wr_x2 = DW'(b);
    bus.wr_t  = DW'(c);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_ctl(input logic rw, input logic nx);
    @(negedge clk);
    bus.rewind = rw;
    bus.next   = nx;
    @(negedge clk);
    bus.rewind = 1'b0;
    bus.next   = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    exp_epoch = 0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({bus.x1, bus.x2, bus.t} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0", {bus.x1, bus.x2, bus.t});
    end
    checks++;
    if ({bus.valid, bus.eof, bus.ovf, bus.full, bus.empty} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=00001",
               {bus.valid, bus.eof, bus.ovf, bus.full, bus.empty});
    end
    checks++;
    if ({bus.count, bus.epoch} !== 13'h0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.count, bus.epoch);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_read();
    for (int i = 0; i < 3; i++) write_sample(sx1[i], sx2[i], st[i]);
    checks++;
    if ({bus.count, bus.valid, bus.empty} !== {5'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL load3 got cnt=%0d v=%b e=%b exp cnt=3 v=0 e=0",
               bus.count, bus.valid, bus.empty);
    end
    for (int i = 0; i < 3; i++) begin
      pulse_ctl(1'b0, 1'b1);
      checks++;
      if ({bus.x1, bus.x2, bus.t} !==
          {DW'(sx1[i]), DW'(sx2[i]), DW'(st[i])}) begin
        errors++;
        $display("FAIL read%0d_data got=%h exp=%h", i,
                 {bus.x1, bus.x2, bus.t},
                 {DW'(sx1[i]), DW'(sx2[i]), DW'(st[i])});
      end
      checks++;
      if ({bus.valid, bus.eof} !== {1'b1, (i == 2)}) begin
        errors++;
        $display("FAIL read%0d_flags got=%b exp=%b", i,
                 {bus.valid, bus.eof}, {1'b1, (i == 2)});
      end
    end
  endtask

  task automatic test_exhausted();
    logic [3*DW-1:0] ed;
    logic ee;
    pulse_ctl(1'b0, 1'b1);
`ifdef FEEDER_AUTO_REWIND_EN
    ed = {DW'(sx1[0]), DW'(sx2[0]), DW'(st[0])};
    ee = 1'b0;
    exp_epoch = 1;
`else
    ed = {DW'(sx1[2]), DW'(sx2[2]), DW'(st[2])};
    ee = 1'b1;
`endif
    checks++;
    if ({bus.x1, bus.x2, bus.t} !== ed) begin
      errors++;
      $display("FAIL exhaust_data got=%h exp=%h", {bus.x1, bus.x2, bus.t}, ed);
    end
    checks++;
    if ({bus.valid, bus.eof, bus.epoch} !== {1'b1, ee, EW'(exp_epoch)}) begin
      errors++;
      $display("FAIL exhaust_flags got v=%b eof=%b ep=%0d exp v=1 eof=%b ep=%0d",
               bus.valid, bus.eof, bus.epoch, ee, exp_epoch);
    end
  endtask

  task automatic test_rewind_next();
    pulse_ctl(1'b1, 1'b0);
    exp_epoch++;
    pulse_ctl(1'b0, 1'b1);
    pulse_ctl(1'b1, 1'b1);
    exp_epoch++;
    checks++;
    if ({bus.valid, bus.eof, bus.epoch} !== {2'b00, EW'(exp_epoch)}) begin
      errors++;
      $display("FAIL rw_next got v=%b eof=%b ep=%0d exp v=0 eof=0 ep=%0d",
               bus.valid, bus.eof, bus.epoch, exp_epoch);
    end
    checks++;
    if ({bus.x1, bus.x2, bus.t} !== {DW'(sx1[0]), DW'(sx2[0]), DW'(st[0])}) begin
      errors++;
      $display("FAIL rw_hold got=%h exp=%h", {bus.x1, bus.x2, bus.t},
               {DW'(sx1[0]), DW'(sx2[0]), DW'(st[0])});
    end
    pulse_ctl(1'b0, 1'b1);
    checks++;
    if ({bus.x1, bus.x2, bus.t, bus.valid, bus.eof} !==
        {DW'(sx1[0]), DW'(sx2[0]), DW'(st[0]), 2'b10}) begin
      errors++;
      $display("FAIL rw_first got=%h v=%b eof=%b exp=%h v=1 eof=0",
               {bus.x1, bus.x2, bus.t}, bus.valid, bus.eof,
               {DW'(sx1[0]), DW'(sx2[0]), DW'(st[0])});
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] ex;
    logic ee;
    pulse_clr();
    checks++;
    if ({bus.count, bus.epoch, bus.valid, bus.eof, bus.x1} !== '0) begin
      errors++;
      $display("FAIL clr got cnt=%0d ep=%0d v=%b eof=%b x1=%h exp all 0",
               bus.count, bus.epoch, bus.valid, bus.eof, bus.x1);
    end
    for (int i = 0; i < 17; i++) write_sample(i, -i, (i % 2) ? 1 : -1);
    checks++;
    if ({bus.count, bus.full, bus.ovf, bus.empty} !== {5'd16, 3'b110}) begin
      errors++;
      $display("FAIL ovf got cnt=%0d f=%b o=%b e=%b exp cnt=16 f=1 o=1 e=0",
               bus.count, bus.full, bus.ovf, bus.empty);
    end
    for (int i = 0; i < 16; i++) begin
      pulse_ctl(1'b0, 1'b1);
      checks++;
      if ({bus.x1, bus.x2, bus.t, bus.eof} !==
          {DW'(i), DW'(-i), DW'((i % 2) ? 1 : -1), (i == 15)}) begin
        errors++;
        $display("FAIL full_rd%0d got=%h eof=%b exp=%h eof=%b", i,
                 {bus.x1, bus.x2, bus.t}, bus.eof,
                 {DW'(i), DW'(-i), DW'((i % 2) ? 1 : -1)}, (i == 15));
      end
    end
    pulse_ctl(1'b0, 1'b1);
`ifdef FEEDER_AUTO_REWIND_EN
    ex = DW'(0);
    ee = 1'b0;
`else
    ex = DW'(15);
    ee = 1'b1;
`endif
    checks++;
    if ({bus.x1, bus.eof} !== {ex, ee}) begin
      errors++;
      $display("FAIL no17th got x1=%0d eof=%b exp x1=%0d eof=%b",
               bus.x1, bus.eof, ex, ee);
    end
  endtask

  task automatic test_empty();
    pulse_clr();
    checks++;
    if (bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL clr_ovf got=%b exp=0", bus.ovf);
    end
    pulse_ctl(1'b0, 1'b1);
    checks++;
    if ({bus.valid, bus.eof, bus.empty, bus.count, bus.epoch} !==
        {3'b001, 5'd0, 8'd0}) begin
      errors++;
      $display("FAIL empty_next got v=%b eof=%b e=%b cnt=%0d ep=%0d exp 0 0 1 0 0",
               bus.valid, bus.eof, bus.empty, bus.count, bus.epoch);
    end
  endtask

  task automatic test_rst_midread();
    for (int i = 0; i < 3; i++) write_sample(sx1[i], sx2[i], st[i]);
    pulse_ctl(1'b1, 1'b0);
    pulse_ctl(1'b0, 1'b1);
    pulse_ctl(1'b0, 1'b1);
    checks++;
    if ({bus.x1, bus.epoch} !== {DW'(sx1[1]), 8'd1}) begin
      errors++;
      $display("FAIL pre_rst got x1=%h ep=%0d exp x1=%h ep=1",
               bus.x1, bus.epoch, DW'(sx1[1]));
    end
    @(negedge clk);
    bus.next = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.x1, bus.x2, bus.t, bus.valid, bus.eof, bus.ovf, bus.full} !== '0) begin
      errors++;
      $display("FAIL async_rst_data got=%h flags=%b exp 0",
               {bus.x1, bus.x2, bus.t},
               {bus.valid, bus.eof, bus.ovf, bus.full});
    end
    checks++;
    if ({bus.count, bus.epoch, bus.empty} !== {5'd0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_rst_cnt got cnt=%0d ep=%0d e=%b exp 0 0 1",
               bus.count, bus.epoch, bus.empty);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.next = 1'b0;
    exp_epoch = 0;
    for (int i = 0; i < 3; i++) write_sample(sx1[i], sx2[i], st[i]);
    pulse_ctl(1'b0, 1'b1);
    checks++;
    if ({bus.x1, bus.x2, bus.t, bus.eof, bus.epoch} !==
        {DW'(sx1[0]), DW'(sx2[0]), DW'(st[0]), 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL post_rst got=%h eof=%b ep=%0d exp=%h eof=0 ep=0",
               {bus.x1, bus.x2, bus.t}, bus.eof, bus.epoch,
               {DW'(sx1[0]), DW'(sx2[0]), DW'(st[0])});
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.clr = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_x1 = '0;
    bus.wr_x2 = '0;
    bus.wr_t = '0;
    bus.next = 1'b0;
    bus.rewind = 1'b0;
    test_reset();
    test_load_read();
    test_exhausted();
    test_rewind_next();
    test_overflow();
    test_empty();
    test_rst_midread();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/train_sample_feeder.md
Name: train_sample_feeder

Overview:
- Upstream data stage for the neuron training datapath.
- Stores a training set of (x1, x2, t) samples loaded through a write port.
- Presents one sample per `next` pulse to the x1/x2/t input registers, with an end-of-set flag (`eof`).
- Supports rewind for a new training epoch.
- Replaces the bare sample counter driven by the training controller's counter-enable and counter-reset strobes.

Parameters:
- DATA_W, 8, width of the signed x1, x2 and t fields (two's complement).
- DEPTH, 16, maximum number of stored samples.
- ADDR_W, 4, pointer width; DEPTH must equal 2**ADDR_W.
- EPOCH_W, 8, width of the epoch counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous clear of the stored set, pointers, flags and epoch counter.
- wr_en  in  1  append one sample.
- wr_x1  in  DATA_W  sample x1.
- wr_x2  in  DATA_W  sample x2.
- wr_t  in  DATA_W  sample target.
- next  in  1  present the next sample (1-cycle pulse).
- rewind  in  1  restart the set at sample 0 (new epoch).
- x1  out  DATA_W  presented x1 (registered).
- x2  out  DATA_W  presented x2 (registered).
- t  out  DATA_W  presented target (registered).
- valid  out  1  x1/x2/t hold a presented sample.
- eof  out  1  presented sample is the last stored sample.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- ovf  out  1  sticky: a write was attempted while full.
- count  out  ADDR_W+1  number of stored samples.
- epoch  out  EPOCH_W  completed rewinds, saturating.

Behaviour:
- Reset (rst=1):
  - count, rd_ptr, x1, x2, t, valid, eof, ovf and epoch all go to 0.
  - empty=1, full=0.
  - Memory contents are undefined after reset and never read before being written.
- Write:
  - On wr_en with !full, mem[count[ADDR_W-1:0]] <= {wr_x1, wr_x2, wr_t} and count increments.
  - On wr_en with full, the write is dropped, count holds and ovf is set.
  - Writes are legal while reading; a newly written sample is presented only if rd_ptr has not yet passed its index.
- Read:
  - State is rd_ptr in the range 0..count.
  - On next with rd_ptr < count:
    - x1/x2/t <= mem[rd_ptr] on the same edge, so outputs update 1 cycle after the next pulse.
    - rd_ptr increments and valid <= 1.
    - eof <= (rd_ptr+1 == count).
  - On next with rd_ptr == count (exhausted, or empty set): no change; outputs, valid and eof hold.
  - Consequence: eof is valid in the cycle after next, which is when the controller's calculate state samples it.
- Rewind:
  - rd_ptr <= 0, eof <= 0, valid <= 0.
  - epoch increments and saturates at all-ones.
  - x1/x2/t hold their last values.
- Priority per cycle: rst > clr > rewind > next.
  - rewind+next in the same cycle performs the rewind only.
  - wr_en is independent of rewind/next, but is suppressed by clr.
- clr: same effect as reset except the memory array, taking effect on the next edge.
- Derived outputs: empty and full are decoded combinationally from count.
- Latency: write to count update is 1 cycle; next to data/eof is 1 cycle; rewind to cleared flags is 1 cycle.

Optional Feature:
- Macro: FEEDER_AUTO_REWIND_EN.
- Defined: next with rd_ptr == count and count > 0 wraps around.
  - The feeder presents mem[0] and sets rd_ptr to 1.
  - eof <= (count == 1) and epoch increments (saturating), exactly as if a rewind and a next had been issued back to back.
- Undefined: next at rd_ptr == count is ignored, as described in Behaviour.
- With count == 0, next is ignored in both builds.

Test Plan:
- Load 3 samples (1,2,+1), (-3,4,-1), (5,-6,+1), then pulse next 3 times → each sample appears 1 cycle after its pulse in order; eof=0, 0, 1; valid=1 from the first presentation.
- After the set is exhausted, a 4th next → outputs still (5,-6,+1) and eof=1 (default build).
  - With FEEDER_AUTO_REWIND_EN defined instead → (1,2,+1), eof=0, epoch=1.
- Write 17 samples with DEPTH=16 → count=16, full=1, ovf=1; the 17th sample is never presented.
- Mid-set, assert rewind and next in the same cycle → rd_ptr=0, valid=0, eof=0, epoch+1; the following next presents sample 0.
- Empty set, pulse next → valid=0, eof=0, empty=1, no state change.
- Assert rst while rd_ptr=2 with next high → all outputs 0 immediately.
  - After release, the memory is reloaded, reading restarts at sample 0 and epoch=0.
